query_bank_loader: RTL and testbench

Double-buffered query staging stage directly downstream of the query parser. It captures the 2-bit query bases that the parser pours one PE at a time, and commits each complete segment of up to PE_NUM bases to the PE array as one parallel bank. While a committed bank is still being processed and the next segment is already staged, it asserts `buffer_full_o` to stall the parser in its WAIT state.

---
 rtl/query_bank_loader_pkg.sv | 16 +
 rtl/query_bank_reg.sv | 34 +++
 rtl/query_bank_loader.sv | 131 +++++++++++++
 tb/tb_query_bank_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/query_bank_loader_pkg.sv
// Shared parameter header for the query staging path: PE array geometry and
// the 2-bit base encoding produced by the query parser.
package query_bank_loader_pkg;

  localparam int PE_NUM     = 64;
  localparam int PE_NUM_BIT = 6;
  localparam int BASE_W     = 2;

  typedef enum logic [BASE_W-1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_t;

endpackage

// File: rtl/query_bank_reg.sv
// PE_NUM x 2-bit register file with a one-hot write port and a per-slot valid
// mask; a write to a slot wins over a simultaneous mask clear.
module query_bank_reg
  import query_bank_loader_pkg::*;
#(
  parameter int SLOTS = PE_NUM
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SLOTS-1:0]          wr_en,
  input  logic [BASE_W-1:0]         wr_data,
  input  logic                      clr,
  output logic [BASE_W*SLOTS-1:0]   data,
  output logic [SLOTS-1:0]          mask
);

  // Data is never cleared by clr; only the mask is, so stale bases remain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      mask <= '0;
    end else begin
      for (int k = 0; k < SLOTS; k++) begin
        if (wr_en[k]) begin
          data[k*BASE_W +: BASE_W] <= wr_data;
          mask[k]                  <= 1'b1;
        end else if (clr) begin
          mask[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/query_bank_loader.sv
// Double-buffered query staging: collects parser bases into a shadow bank and
// commits whole segments to the PE array, stalling the parser when both are full.
module query_bank_loader #(
  parameter int PE_NUM     = query_bank_loader_pkg::PE_NUM,
  parameter int PE_NUM_BIT = query_bank_loader_pkg::PE_NUM_BIT
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [query_bank_loader_pkg::BASE_W-1:0]      q_i,
  input  logic [PE_NUM-1:0]                             pe_valid_i,
  input  logic                                          pouring_i,
  input  logic                                          pouring_last_i,
  input  logic                                          parser_busy_i,
  input  logic                                          seg_done_i,
  output logic                                          buffer_full_o,
  output logic [query_bank_loader_pkg::BASE_W*PE_NUM-1:0] q_bank_o,
  output logic [PE_NUM-1:0]                             pe_en_o,
  output logic                                          seg_load_o,
  output logic                                          seg_last_o,
  output logic                                          overflow_o
);

  import query_bank_loader_pkg::*;

  if ((1 << PE_NUM_BIT) != PE_NUM) begin : g_bad_pe_num
    $error("query_bank_loader: PE_NUM must equal 2**PE_NUM_BIT");
  end

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                     state, state_nxt;
  logic                       commit;
  logic                       act_busy;
  logic                       last_pend;
  logic                       last_now;
  logic                       seg_end;
  logic                       has_data;
  logic                       act_free;
  logic [PE_NUM-1:0]          wr_en;
  logic [PE_NUM-1:0]          sh_mask;
  logic [BASE_W*PE_NUM-1:0]   sh_q;

  assign seg_end  = pouring_last_i & ~pouring_i;
  assign has_data = |sh_mask;
  assign act_free = ~act_busy | seg_done_i;
  assign wr_en    = (state == FILL) ? pe_valid_i : '0;
  // The final-segment flag must be usable on the very edge that sees seg_end.
  assign last_now = (state == FILL && seg_end) ? ~parser_busy_i : last_pend;

  query_bank_reg #(
    .SLOTS (PE_NUM)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (q_i),
    .clr     (commit),
    .data    (sh_q),
    .mask    (sh_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      FILL: begin
        if (seg_end && has_data) begin
          if (act_free) begin
            commit = 1'b1;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (act_free) begin
          commit    = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pend <= 1'b0;
    end else if (state == FILL && seg_end && has_data) begin
      last_pend <= ~parser_busy_i;
    end
  end

  // A commit re-arms act_busy even when seg_done_i frees the previous bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_busy      <= 1'b0;
      q_bank_o      <= '0;
      pe_en_o       <= '0;
      seg_load_o    <= 1'b0;
      seg_last_o    <= 1'b0;
      buffer_full_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      seg_load_o    <= commit;
      buffer_full_o <= (state_nxt == HOLD);
      if (commit) begin
        act_busy   <= 1'b1;
        q_bank_o   <= sh_q;
        pe_en_o    <= sh_mask;
        seg_last_o <= last_now;
      end else if (seg_done_i) begin
        act_busy <= 1'b0;
      end
      if (state == HOLD && |pe_valid_i) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_query_bank_loader.sv
// Directed self-checking bench for query_bank_loader: full bank, stall/HOLD,
// overflow, final segment, coincident done, empty segment and reset in HOLD.
module tb_query_bank_loader;

  localparam int PE_NUM = 64;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            q;
  logic [PE_NUM-1:0]     pe_valid;
  logic                  pouring;
  logic                  pouring_last;
  logic                  parser_busy;
  logic                  seg_done;
  logic                  buffer_full;
  logic [2*PE_NUM-1:0]   q_bank;
  logic [PE_NUM-1:0]     pe_en;
  logic                  seg_load;
  logic                  seg_last;
  logic                  overflow;

  int tests_run;
  int tests_failed;

  logic [2*PE_NUM-1:0] bank1_exp;
  logic [2*PE_NUM-1:0] bank2_exp;

  query_bank_loader #(
    .PE_NUM     (64),
    .PE_NUM_BIT (6)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .q_i            (q),
    .pe_valid_i     (pe_valid),
    .pouring_i      (pouring),
    .pouring_last_i (pouring_last),
    .parser_busy_i  (parser_busy),
    .seg_done_i     (seg_done),
    .buffer_full_o  (buffer_full),
    .q_bank_o       (q_bank),
    .pe_en_o        (pe_en),
    .seg_load_o     (seg_load),
    .seg_last_o     (seg_last),
    .overflow_o     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] base_val(input int mode, input int k);
    case (mode)
      0:       return 2'(k % 4);
      1:       return 2'(3 - (k % 4));
      default: return 2'((k + 2) % 4);
    endcase
  endfunction

  // One base per cycle into slots 0..n-1, driven on the falling edge.
  task automatic pour(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pe_valid    = '0;
      pe_valid[k] = 1'b1;
      q           = base_val(mode, k);
      pouring_last = pouring;
      pouring     = 1'b1;
    end
  endtask

  // Segment-end cycle t; returns at the falling edge of cycle t+1.
  task automatic end_segment(input logic busy, input logic done);
    @(negedge clk);
    pe_valid     = '0;
    pouring      = 1'b0;
    pouring_last = 1'b1;
    parser_busy  = busy;
    seg_done     = done;
    @(negedge clk);
    pouring_last = 1'b0;
    parser_busy  = 1'b1;
    seg_done     = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    seg_done = 1'b1;
    @(negedge clk);
    seg_done = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (buffer_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_buffer_full: got %b expected 0", buffer_full);
    end
    tests_run++;
    if (seg_load !== 1'b0 || seg_last !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got load=%b last=%b ovf=%b expected 0 0 0", seg_load, seg_last, overflow);
    end
    tests_run++;
    if (q_bank !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_q_bank: got %h expected 0", q_bank);
    end
    tests_run++;
    if (pe_en !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pe_en: got %h expected 0", pe_en);
    end
  endtask

  task automatic test_full_bank();
    pour(64, 0);
    end_segment(1'b1, 1'b0);
    tests_run++;
    if (seg_load !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_seg_load: got %b expected 1", seg_load);
    end
    tests_run++;
    if (q_bank !== bank1_exp) begin
      tests_failed++;
      $display("[TB] FAIL full_q_bank: got %h expected %h", q_bank, bank1_exp);
    end
    tests_run++;
    if (pe_en !== {PE_NUM{1'b1}}) begin
      tests_failed++;
      $display("[TB] FAIL full_pe_en: got %h expected all ones", pe_en);
    end
    tests_run++;
    if (buffer_full !== 1'b0 || seg_last !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_status: got full=%b last=%b expected 0 0", buffer_full, seg_last);
    end
    @(negedge clk);
    tests_run++;
    if (seg_load !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_load_pulse: got %b expected 0", seg_load);
    end
  endtask

  task automatic test_stall();
    pour(64, 1);
    end_segment(1'b1, 1'b0);
    tests_run++;
    if (buffer_full !== 1'b1 || seg_load !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_enter: got full=%b load=%b expected 1 0", buffer_full, seg_load);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (buffer_full !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall_held: got %b expected 1", buffer_full);
    end
    tests_run++;
    if (q_bank !== bank1_exp) begin
      tests_failed++;
      $display("[TB] FAIL stall_active_kept: got %h expected %h", q_bank, bank1_exp);
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    pe_valid    = '0;
    pe_valid[0] = 1'b1;
    q           = 2'd0;
    @(negedge clk);
    pe_valid = '0;
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL overflow_set: got %b expected 1", overflow);
    end
  endtask

  task automatic test_hold_exit();
    pulse_done();
    tests_run++;
    if (seg_load !== 1'b1 || buffer_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL hold_exit: got load=%b full=%b expected 1 0", seg_load, buffer_full);
    end
    tests_run++;
    if (q_bank !== bank2_exp) begin
      tests_failed++;
      $display("[TB] FAIL hold_exit_bank: got %h expected %h", q_bank, bank2_exp);
    end
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow);
    end
  endtask

  task automatic test_last_segment();
    logic [2*PE_NUM-1:0] stale;
    stale = bank2_exp;
    pulse_done();
    pour(10, 2);
    end_segment(1'b0, 1'b0);
    tests_run++;
    if (seg_load !== 1'b1 || seg_last !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL last_flags: got load=%b last=%b expected 1 1", seg_load, seg_last);
    end
    tests_run++;
    if (pe_en !== 64'h3FF) begin
      tests_failed++;
      $display("[TB] FAIL last_pe_en: got %h expected 3ff", pe_en);
    end
    tests_run++;
    if (q_bank[19:0] !== 20'hE4E4E || q_bank[127:20] !== stale[127:20]) begin
      tests_failed++;
      $display("[TB] FAIL last_q_bank: got %h expected low 20 bits e4e4e over stale %h", q_bank, stale);
    end
  endtask

  task automatic test_done_coincident();
    pour(4, 0);
    end_segment(1'b1, 1'b1);
    tests_run++;
    if (seg_load !== 1'b1 || buffer_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL coincident_commit: got load=%b full=%b expected 1 0", seg_load, buffer_full);
    end
    tests_run++;
    if (pe_en !== 64'hF || q_bank[7:0] !== 8'hE4 || seg_last !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL coincident_bank: got en=%h q=%h last=%b expected f e4 0", pe_en, q_bank[7:0], seg_last);
    end
  endtask

  task automatic test_empty_seg_end();
    end_segment(1'b1, 1'b0);
    tests_run++;
    if (seg_load !== 1'b0 || buffer_full !== 1'b0 || pe_en !== 64'hF) begin
      tests_failed++;
      $display("[TB] FAIL empty_seg_end: got load=%b full=%b en=%h expected 0 0 f", seg_load, buffer_full, pe_en);
    end
  endtask

  task automatic test_reset_in_hold();
    pour(5, 0);
    end_segment(1'b1, 1'b0);
    tests_run++;
    if (buffer_full !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_hold_enter: got %b expected 1", buffer_full);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (buffer_full !== 1'b0 || pe_en !== '0 || seg_load !== 1'b0 || q_bank !== '0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_async: got full=%b en=%h load=%b q=%h ovf=%b expected all 0", buffer_full, pe_en, seg_load, q_bank, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pour(3, 0);
    end_segment(1'b1, 1'b0);
    tests_run++;
    if (seg_load !== 1'b1 || buffer_full !== 1'b0 || pe_en !== 64'h7) begin
      tests_failed++;
      $display("[TB] FAIL rst_after_load: got load=%b full=%b en=%h expected 1 0 7", seg_load, buffer_full, pe_en);
    end
    tests_run++;
    if (q_bank !== 128'h24) begin
      tests_failed++;
      $display("[TB] FAIL rst_after_bank: got %h expected 24", q_bank);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    bank1_exp    = {16{8'hE4}};
    bank2_exp    = {16{8'h1B}};
    rst_n        = 1'b0;
    q            = 2'd0;
    pe_valid     = '0;
    pouring      = 1'b0;
    pouring_last = 1'b0;
    parser_busy  = 1'b1;
    seg_done     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_full_bank();
    test_stall();
    test_overflow();
    test_hold_exit();
    test_last_segment();
    test_done_coincident();
    test_empty_seg_end();
    test_reset_in_hold();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
